regfile_writeback: RTL

Write-side controller for the 32×32 register file. It merges single-cycle ALU results and out-of-order-returning load data onto the file's single write port (A3/WE3/WD3). It buffers load returns in a small FIFO and keeps a pending-load scoreboard for hazard detection. It sits between the execute/memory stages and `RegisterFile`.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_load_fifo.sv | 55 +++++
 rtl/regfile_writeback.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the writeback controller, RegisterFile and the hazard unit.
package regfile_pkg;

   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 32;
   localparam int REG_COUNT = 32;
   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Small synchronous FIFO holding returned load results until they win the write port.
module wb_load_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  logic    pop,
   input  wb_req_t din,
   output logic    full,
   output logic    empty,
   output wb_req_t head
);

   localparam int PW = $clog2(DEPTH);

   wb_req_t        mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW:0]    count;
   logic           do_push;
   logic           do_pop;

   // Full/empty come only from the registered count, so a pop never frees a slot for the same edge.
   always_comb begin
      full    = (count == (PW+1)'(DEPTH));
      empty   = (count == '0);
      do_push = push && !full;
      do_pop  = pop && !empty;
      head    = mem[rd_ptr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU results and buffered load returns onto the register file's single write port,
// tracking outstanding loads so a later ALU write to the same register cannot overtake them.
module regfile_writeback
   import regfile_pkg::wb_req_t, regfile_pkg::ZERO_REG;
#(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int LQ_DEPTH     = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              ld_issue,
   input  logic [ADDR_W-1:0] ld_issue_rd,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_rd,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic [ADDR_W-1:0] A3,
   output logic              WE3,
   output logic [DATA_W-1:0] WD3,
   output logic [31:0]       pend
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   wb_req_t           lq_in;
   wb_req_t           lq_head;
   logic              lq_full;
   logic              lq_empty;
   logic              alu_req;
   logic              fifo_grant;
   logic              any_grant;
   logic [ADDR_W-1:0] grant_rd;
   logic [DATA_W-1:0] grant_data;
   logic [SW-1:0]     starve_cnt;
   logic [31:0]       pend_next;

   always_comb begin
      lq_in.rd   = ld_rd;
      lq_in.data = ld_data;
      ld_ready   = !lq_full;
   end

   wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_load_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (ld_valid),
      .pop   (fifo_grant),
      .din   (lq_in),
      .full  (lq_full),
      .empty (lq_empty),
      .head  (lq_head)
   );

   // ALU stalls on a pending load to its destination (keeps write order) or once it has starved the FIFO.
   always_comb begin
      alu_ready  = !((alu_rd != ZERO_REG) && pend[alu_rd]) &&
                   (starve_cnt != SW'(STARVE_LIMIT));
      alu_req    = alu_valid && alu_ready;
      fifo_grant = !alu_req && !lq_empty;
      any_grant  = alu_req || fifo_grant;
      grant_rd   = alu_req ? alu_rd   : lq_head.rd;
      grant_data = alu_req ? alu_data : lq_head.data;
   end

   // Issue-side set takes priority over the writeback-side clear of the same register.
   always_comb begin
      pend_next = pend;
      if (fifo_grant && (lq_head.rd != ZERO_REG)) pend_next[lq_head.rd] = 1'b0;
      if (ld_issue && (ld_issue_rd != ZERO_REG))  pend_next[ld_issue_rd] = 1'b1;
      pend_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         A3         <= '0;
         WE3        <= 1'b0;
         WD3        <= '0;
         pend       <= '0;
         starve_cnt <= '0;
      end else begin
         WE3  <= any_grant && (grant_rd != ZERO_REG);
         pend <= pend_next;
         if (any_grant) begin
            A3  <= grant_rd;
            WD3 <= grant_data;
         end
         if (lq_empty || fifo_grant)
            starve_cnt <= '0;
         else if (alu_req && (starve_cnt != SW'(STARVE_LIMIT)))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule
